// File: rtl/rr_arb8_ctl.sv
// Eight-requester round-robin arbiter with a registered grant, a per-grant hold limit
// and a one-cycle timeout pulse after a forced release.
module rr_arb8_ctl #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       en,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       tout
);

  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;
  localparam int unsigned HW = 8;
  localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_MAX);
  localparam logic          HOLD_ON  = (HOLD_MAX != 0);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          vld_q, vld_d;
  logic          tout_q, tout_d;

  logic          pick_ok;
  logic [IW-1:0] pick;
  logic [IW-1:0] cand;

  // First requester found scanning upward from the priority pointer, wrapping at 8.
  always_comb begin
    pick_ok = 1'b0;
    pick    = ptr_q;
    cand    = ptr_q;
    for (int unsigned k = 0; k < N; k++) begin
      cand = ptr_q + IW'(k);
      if (!pick_ok && req[cand]) begin
        pick_ok = 1'b1;
        pick    = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hcnt_d  = hcnt_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    tout_d  = 1'b0;

    case (state_q)
      IDLE: begin
        gnt_d = '0;
        vld_d = 1'b0;
        if (en && pick_ok) begin
          state_d     = GRANT;
          idx_d       = pick;
          gnt_d[pick] = 1'b1;
          vld_d       = 1'b1;
          ptr_d       = pick + IW'(1);
          hcnt_d      = HW'(1);
        end
      end
      GRANT: begin
        // A normal release outranks the hold limit, so a coincident done never times out.
        if (done || !req[idx_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          vld_d   = 1'b0;
        end else if (HOLD_ON && (hcnt_q == HOLD_LIM)) begin
          state_d = IDLE;
          gnt_d   = '0;
          vld_d   = 1'b0;
          tout_d  = 1'b1;
        end else if (hcnt_q != {HW{1'b1}}) begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hcnt_q  <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hcnt_q  <= hcnt_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      tout_q  <= tout_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_vld = vld_q;
  assign tout    = tout_q;

endmodule

// File: tb/tb_rr_arb8_ctl.sv
// Bench for rr_arb8_ctl: directed scenarios plus random traffic, all checked against
// a cycle-level behavioural model of the arbitration rules.
module tb_rr_arb8_ctl;

  localparam int unsigned HM = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       en = 1'b0;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       tout;

  int total = 0;
  int bad = 0;

  // Reference model state
  bit m_busy = 1'b0;
  int m_idx  = 0;
  int m_ptr  = 0;
  int m_hcnt = 0;
  bit m_tout = 1'b0;

  rr_arb8_ctl #(.HOLD_MAX(HM)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .en     (en),
    .done   (done),
    .gnt    (gnt),
    .gnt_idx(gnt_idx),
    .gnt_vld(gnt_vld),
    .tout   (tout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs presented in the cycle.
  task automatic model_edge();
    int best_d;
    int best_i;
    if (!rst_n) begin
      m_busy = 1'b0; m_idx = 0; m_ptr = 0; m_hcnt = 0; m_tout = 1'b0;
    end else if (!m_busy) begin
      m_tout = 1'b0;
      best_d = 8;
      best_i = 0;
      for (int i = 0; i < 8; i++) begin
        if (req[i] && ((i - m_ptr + 8) % 8) < best_d) begin
          best_d = (i - m_ptr + 8) % 8;
          best_i = i;
        end
      end
      if (en && best_d < 8) begin
        m_busy = 1'b1;
        m_idx  = best_i;
        m_ptr  = (best_i + 1) % 8;
        m_hcnt = 1;
      end
    end else begin
      m_tout = 1'b0;
      if (done || !req[m_idx]) begin
        m_busy = 1'b0;
      end else if (HM != 0 && m_hcnt == int'(HM)) begin
        m_busy = 1'b0;
        m_tout = 1'b1;
      end else if (m_hcnt < 255) begin
        m_hcnt = m_hcnt + 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("gnt", 32'(gnt), m_busy ? (32'd1 << m_idx) : 32'd0);
    check("gnt_idx", 32'(gnt_idx), 32'(m_idx));
    check("gnt_vld", 32'(gnt_vld), 32'(m_busy));
    check("tout", 32'(tout), 32'(m_tout));
  endtask

  initial begin
    // Reset with all requests pending
    rst_n = 1'b0; req = 8'hFF; en = 1'b1; done = 1'b0;
    step(); step();
    check("rst_gnt", 32'(gnt), 32'h00);
    check("rst_vld", 32'(gnt_vld), 32'd0);
    check("rst_idx", 32'(gnt_idx), 32'd0);
    check("rst_tout", 32'(tout), 32'd0);
    rst_n = 1'b1;
    step();
    check("first_gnt", 32'(gnt), 32'h01);

    // Round-robin wrap with one-cycle done pulses
    for (int i = 1; i <= 8; i++) begin
      done = 1'b1; step();
      check("rr_bubble", 32'(gnt_vld), 32'd0);
      done = 1'b0; step();
      check("rr_idx", 32'(gnt_idx), 32'(i % 8));
    end

    // Pointer skip: grant 5, then sparse requests 0 and 2
    done = 1'b1; req = 8'h20; step();
    done = 1'b0; step();
    check("skip_g5", 32'(gnt_idx), 32'd5);
    req = 8'h05; step();
    step();
    check("skip_g0", 32'(gnt), 32'h01);
    done = 1'b1; step(); done = 1'b0; step();
    check("skip_g2", 32'(gnt), 32'h04);
    done = 1'b1; step(); done = 1'b0; step();
    check("skip_g0b", 32'(gnt), 32'h01);

    // Hold limit with forced release, then a done on the last allowed cycle
    req = 8'h08; step();
    step();
    check("hold_g3", 32'(gnt), 32'h08);
    step(); step(); step();
    check("hold_last", 32'(gnt), 32'h08);
    step();
    check("hold_tout", 32'(tout), 32'd1);
    check("hold_rel", 32'(gnt), 32'h00);
    step();
    check("hold_regnt", 32'(gnt), 32'h08);
    check("hold_tout_clr", 32'(tout), 32'd0);
    step(); step(); step();
    done = 1'b1; step();
    check("hold_done_tout", 32'(tout), 32'd0);
    check("hold_done_rel", 32'(gnt_vld), 32'd0);
    done = 1'b0;

    // Enable drop keeps the grant; request drop releases; en gates the next grant
    req = 8'h04; step();
    check("en_g2", 32'(gnt_idx), 32'd2);
    en = 1'b0; step(); step();
    check("en_hold", 32'(gnt), 32'h04);
    req = 8'h80; step();
    check("drop_rel", 32'(gnt_vld), 32'd0);
    step(); step();
    check("en_block", 32'(gnt_vld), 32'd0);
    en = 1'b1; step();
    check("en_g7", 32'(gnt), 32'h80);

    // Reset in the middle of a grant
    done = 1'b1; step(); done = 1'b0;
    req = 8'h20; step();
    check("mid_g5", 32'(gnt_idx), 32'd5);
    rst_n = 1'b0; step();
    check("mid_rst_gnt", 32'(gnt), 32'h00);
    check("mid_rst_tout", 32'(tout), 32'd0);
    rst_n = 1'b1; req = 8'hFF; step();
    check("mid_regnt", 32'(gnt), 32'h01);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      en    = ($urandom_range(0, 9) != 0);
      done  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) != 0) req = 8'($urandom) & 8'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arb8_ctl.md
# rr_arb8_ctl

Round-robin scheduler that shares one resource among 8 requesters. Each cycle it is idle, it picks one requester and produces a registered 3-bit grant index, which drives the team's 3-to-8 decoder path, plus a matching one-hot grant vector. A grant is held until the grantee signals completion, drops its request, or exceeds a hold limit. It sits between the requesting units and the decoded select lines of the shared datapath.

## Interface
- `HOLD_MAX`, default 15: maximum consecutive GRANT cycles per grant; legal range 0..255; 0 means unlimited.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req`  in  8  request vector; bit i is requester i.
- `en`  in  1  arbitration enable; when 0, no new grant is issued.
- `done`  in  1  the current grantee releases the resource.
- `gnt`  out  8  one-hot grant, registered; equals decode(`gnt_idx`) when `gnt_vld`=1, else 0.
- `gnt_idx`  out  3  index of the current grantee, registered.
- `gnt_vld`  out  1  a grant is active.
- `tout`  out  1  one-cycle pulse: the last grant was force-released on hold limit.

## Operation
- Two states, IDLE and GRANT.
- Reset (`rst_n`=0 at a rising edge) gives:
  - state=IDLE, `gnt`=8'h00, `gnt_idx`=3'd0, `gnt_vld`=0, `tout`=0.
  - Priority pointer `ptr`=0; hold counter `hcnt`=0.
  - Reset overrides everything, including a grant in progress; no `tout` is produced.
- IDLE: if `en`=1 and `req`≠0, select the first set bit scanning `ptr`, `ptr`+1, …, `ptr`+7 (mod 8).
  - Next state GRANT with `gnt_idx`=i, `gnt`=1<<i, `gnt_vld`=1.
  - `ptr` ← (i+1) mod 8, so 7 wraps to 0.
  - `hcnt` ← 1.
- IDLE with `en`=0 or `req`=0: remain in IDLE; outputs 0; `ptr` unchanged.
- GRANT: release conditions are evaluated every cycle, in this priority:
  1. `done`=1, or `req[gnt_idx]`=0: release normally; next state IDLE, `tout` stays 0.
  2. Otherwise, if `HOLD_MAX`≠0 and `hcnt`==`HOLD_MAX`: forced release; next state IDLE and `tout`=1 for exactly that IDLE cycle.
  3. Otherwise stay in GRANT with `hcnt`+1; `hcnt` saturates at 255 when `HOLD_MAX`=0.
- `done` together with the hold limit in the same cycle counts as a normal release: `tout`=0.
- `done` asserted while in IDLE is ignored.
- `en` going low during GRANT does not revoke the current grant; it only blocks the next one.
- `gnt_idx` keeps its last value in IDLE. Consumers must qualify it with `gnt_vld`.
- Requests that change while in GRANT have no effect until the next IDLE cycle, except `req[gnt_idx]` falling, which releases the grant.

## Timing
- Grant latency: `req` sampled at edge k (state IDLE) gives `gnt`/`gnt_vld` high from edge k, i.e. visible in the cycle after the request was presented.
- Release: `done` high in the cycle before edge m gives `gnt`=0 after edge m. This is one mandatory IDLE bubble cycle. The earliest next grant is after edge m+1.
- Hold: with no release, a grant is high for exactly `HOLD_MAX` cycles, then one IDLE cycle with `tout`=1.
- Back-to-back throughput: at most one grant per 2 cycles with single-cycle holds.
- All outputs are direct register outputs; there is no combinational input-to-output path.

## Test plan
- Reset: drive `rst_n`=0 for 2 cycles while `req`=8'hFF and `en`=1 → `gnt`=0, `gnt_vld`=0, `gnt_idx`=0, `tout`=0. After release of reset, the first grant goes to index 0 (`gnt`=8'h01).
- Round-robin wrap: `req`=8'hFF held, `en`=1, `done` pulsed 1 cycle per grant → grant order 0,1,2,…,7,0, with one `gnt`=0 bubble between grants.
- Pointer skip: `ptr`=6 (after granting 5), `req`=8'b0000_0101 → grant index 0, then index 2, then index 0.
- Hold limit: `HOLD_MAX`=4, `req`=8'h08, `done`=0 → `gnt`=8'h08 for 4 cycles, then `gnt`=0 with `tout`=1 for 1 cycle, then a re-grant to index 3 with `tout`=0. Repeat the hold with `done`=1 on the 4th cycle → `tout` stays 0.
- Enable and request drop: grant index 2 active, then `en`←0 → the grant persists. Drop `req[2]` → release; no further grant while `en`=0 even with `req`=8'h80. Raise `en` → grant index 7.
- Reset mid-grant: during GRANT to index 5, `rst_n`=0 for 1 cycle → all outputs 0 and `tout`=0. With `req`=8'hFF the next grant is index 0.
